// File: rtl/bcd_countdown.sv
// BCD countdown timer with penalty deduction, pause/abort control and expiry flag.
// Count is held as DIGITS packed BCD digits; all arithmetic stays in BCD.
module bcd_countdown #(
    parameter int                    DIGITS     = 3,
    parameter logic [4*DIGITS-1:0]   RESET_TIME = 'h200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   init_time,
    input  logic                  load,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  abort,
    input  logic                  tick,
    input  logic                  penalty,
    input  logic [4*DIGITS-1:0]   penalty_time,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  expired,
    output logic                  expire_pulse
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_EXPIRED
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_count;
    logic           r_running;
    logic           r_expired;
    logic           r_expire_pulse;

    logic           w_tick_en;
    logic           w_pen_en;
    logic           w_update;
    logic           w_borrow;
    logic [W-1:0]   w_sub_amt;
    logic [W-1:0]   w_diff;
    logic [W-1:0]   w_next_count;
    logic           w_hit_zero;

    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] res;
        res = '0;
        for (int i = 0; i < DIGITS; i++) begin
            res[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        end
        return res;
    endfunction

    // Ripple BCD subtraction; 4-bit modular arithmetic is exact because every digit result lands in 0..9.
    function automatic logic [W:0] bcd_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
        logic [W-1:0] res;
        logic         br;
        logic         lt;
        logic [3:0]   ad;
        logic [3:0]   bd;
        res = '0;
        br  = bin;
        for (int i = 0; i < DIGITS; i++) begin
            ad = a[4*i +: 4];
            bd = b[4*i +: 4];
            lt = ({1'b0, ad} < ({1'b0, bd} + {4'd0, br}));
            res[4*i +: 4] = lt ? (ad + 4'd10 - bd - {3'd0, br}) : (ad - bd - {3'd0, br});
            br = lt;
        end
        return {br, res};
    endfunction

    always_comb begin
        w_tick_en = tick && (r_state == S_RUN);
        w_pen_en  = penalty && ((r_state == S_RUN) || (r_state == S_PAUSE));
        w_update  = w_tick_en || w_pen_en;
        // Out-of-range penalty digits are clamped so the subtractor never sees a non-BCD digit.
        w_sub_amt = w_pen_en ? bcd_clamp(penalty_time) : '0;
        {w_borrow, w_diff} = bcd_sub(r_count, w_sub_amt, w_tick_en);
        w_next_count = w_borrow ? '0 : w_diff;
        w_hit_zero   = w_update && (w_next_count == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_count        <= RESET_TIME;
            r_running      <= 1'b0;
            r_expired      <= 1'b0;
            r_expire_pulse <= 1'b0;
        end else begin
            r_expire_pulse <= 1'b0;
            if (load) begin
                r_state   <= S_IDLE;
                r_count   <= bcd_clamp(init_time);
                r_running <= 1'b0;
                r_expired <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!abort && !pause && start && (r_count != '0)) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    S_RUN, S_PAUSE: begin
                        if (abort) begin
                            r_state   <= S_IDLE;
                            r_running <= 1'b0;
                        end else begin
                            if (w_update) begin
                                r_count <= w_next_count;
                            end
                            // Reaching zero wins over a simultaneous pause or start.
                            if (w_hit_zero) begin
                                r_state        <= S_EXPIRED;
                                r_running      <= 1'b0;
                                r_expired      <= 1'b1;
                                r_expire_pulse <= 1'b1;
                            end else if (pause) begin
                                r_state   <= S_PAUSE;
                                r_running <= 1'b0;
                            end else if (start) begin
                                r_state   <= S_RUN;
                                r_running <= 1'b1;
                            end
                        end
                    end
                    S_EXPIRED: begin
                        r_running <= 1'b0;
                        r_expired <= 1'b1;
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_running <= 1'b0;
                        r_expired <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign count        = r_count;
    assign running      = r_running;
    assign expired      = r_expired;
    assign expire_pulse = r_expire_pulse;

endmodule

// File: doc/bcd_countdown.md
BCD_COUNTDOWN -- requirements
Module: bcd_countdown

Interface
REQ-001 SHALL provide parameter DIGITS, default 3, number of BCD digits (range 1..8).
REQ-002 SHALL provide parameter RESET_TIME, default 'h200 (4*DIGITS bits), BCD count value loaded by reset.
REQ-003 SHALL provide port clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL provide port init_time  in  4*DIGITS  BCD start value; digit 0 = bits [3:0], the rightmost digit.
REQ-006 SHALL provide port load  in  1  when high, copies init_time into count.
REQ-007 SHALL provide port start  in  1  when high, begins or resumes counting.
REQ-008 SHALL provide port pause  in  1  when high, suspends counting.
REQ-009 SHALL provide port abort  in  1  when high, stops counting and freezes count (defused).
REQ-010 SHALL provide port tick  in  1  one-clk pulse marking one elapsed second.
REQ-011 SHALL provide port penalty  in  1  one-clk pulse requesting a time deduction.
REQ-012 SHALL provide port penalty_time  in  4*DIGITS  BCD amount to deduct on penalty.
REQ-013 SHALL provide port count  out  4*DIGITS  registered BCD remaining time.
REQ-014 SHALL provide port running  out  1  high in RUN only.
REQ-015 SHALL provide port expired  out  1  high in EXPIRED only.
REQ-016 SHALL provide port expire_pulse  out  1  one-clk pulse on entry to EXPIRED.

Function
REQ-017 SHALL implement states IDLE, RUN, PAUSE and EXPIRED.
REQ-018 SHALL accept control inputs in the priority order load > abort > pause > start.
REQ-019 SHALL, on load in any state, set count to init_time, enter IDLE and clear expired.
REQ-020 SHALL clamp, during load, any init_time digit greater than 9 to 9.
REQ-021 SHALL move IDLE->RUN on start when count != 0; start SHALL be ignored when count == 0.
REQ-022 SHALL move RUN->PAUSE on pause and PAUSE->RUN on start.
REQ-023 SHALL move RUN or PAUSE to IDLE on abort, with count held at its current value.
REQ-024 SHALL leave EXPIRED only on load or reset.
REQ-025 SHALL, on tick in RUN, decrement count by 1 as a multi-digit BCD decrement: a digit at 0 becomes 9 and borrows from the next digit.
REQ-026 SHALL, on penalty in RUN or PAUSE, subtract penalty_time from count in BCD, saturating at 0.
REQ-027 SHALL, on tick and penalty in the same RUN cycle, subtract penalty_time+1 in that single cycle, saturating at 0.
REQ-028 SHALL ignore tick outside RUN, and SHALL ignore penalty in IDLE and EXPIRED.
REQ-029 SHALL, when a tick or penalty update makes count 0, enter EXPIRED on the same edge, assert expire_pulse for exactly 1 cycle and hold expired high.
REQ-030 SHALL give 1-cycle latency: a tick or penalty sampled at edge N is visible on count after edge N.
REQ-031 SHALL keep every count digit within 0..9 at all times; no wrap from 0 to all-9s.
REQ-032 SHALL, when load coincides with tick or penalty, perform the load and discard the tick or penalty.
REQ-033 SHALL, when pause coincides with tick in RUN, apply the tick and enter PAUSE.
REQ-034 SHALL, when a tick or penalty in RUN reaches 0 while pause is high, give expiry precedence: enter EXPIRED, not PAUSE.

Reset
REQ-035 SHALL, while reset is high, force state IDLE, count = RESET_TIME, running = 0, expired = 0 and expire_pulse = 0, independent of clk.
REQ-036 SHALL, when reset is asserted mid-count, abandon the count with no expire_pulse; operation resumes from IDLE after reset is released.

Verification (DIGITS=3)
REQ-037 Bench SHALL check: reset, then load init_time=h100, start, 1 tick -> count=h099 (borrow across two digits), running=1.
REQ-038 Bench SHALL check: count=h002, 2 ticks in RUN -> count=h000, expire_pulse high exactly 1 cycle, expired=1, further ticks leave h000.
REQ-039 Bench SHALL check: count=h045 in RUN, penalty with penalty_time=h030 and tick in the same cycle -> count=h014; then penalty h030 -> count=h000 and expired=1.
REQ-040 Bench SHALL check: count=h120, pause, 5 ticks -> count stays h120; start, 1 tick -> h119.
REQ-041 Bench SHALL check: count=h057 in RUN, abort -> IDLE with count=h057 held; ticks ignored; load init_time=hFA3 -> count=h993.
REQ-042 Bench SHALL check: reset asserted asynchronously between clk edges during RUN -> count=h200 and running=0 immediately, expire_pulse never asserted.
